// File: rtl/mem_io_bridge_if.sv
// Bus bundle between the CPU control unit, the board I/O and the external SRAM.
// The bridge uses the slave view; the environment driving it uses the master view.
interface mem_io_bridge_if;
    logic        Mem_CE;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [15:0] ADDR;
    logic [15:0] Data_CPU;
    logic [15:0] Data_to_CPU;
    logic        Mem_Ready;
    logic [15:0] SW;
    logic [15:0] HEX_Data;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic [15:0] SRAM_DQ_in;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic        Err_Flag;

    modport slave (
        input  Mem_CE, Mem_OE, Mem_WE, ADDR, Data_CPU, SW, SRAM_DQ_in,
        output Data_to_CPU, Mem_Ready, HEX_Data, SRAM_ADDR,
               SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_out, SRAM_DQ_oe, Err_Flag
    );

    modport master (
        output Mem_CE, Mem_OE, Mem_WE, ADDR, Data_CPU, SW, SRAM_DQ_in,
        input  Data_to_CPU, Mem_Ready, HEX_Data, SRAM_ADDR,
               SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_out, SRAM_DQ_oe, Err_Flag
    );
endinterface

// File: rtl/mem_io_bridge.sv
// Bridges CPU memory strobes to an asynchronous SRAM with programmable wait states,
// and maps one address onto the board switches (read) and hex display (write).
module mem_io_bridge #(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic           Clk,
    input  logic           Reset,
    mem_io_bridge_if.slave bus
);

    typedef enum logic [2:0] {IDLE, ACCESS, IO, DONE, RELEASE} state_t;

    state_t      state, next_state;
    logic [15:0] addr_q, data_q, dout_q, hex_q;
    logic [15:0] sw_meta, sw_sync;
    logic [3:0]  cnt;
    logic        is_write, err_q;
    logic        accept, illegal;
    logic        ce_n, oe_n, we_n, dq_oe, ready;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        illegal    = 1'b0;
        ce_n       = 1'b1;
        oe_n       = 1'b1;
        we_n       = 1'b1;
        dq_oe      = 1'b0;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.Mem_CE) begin
                    accept  = bus.Mem_OE ^ bus.Mem_WE;
                    illegal = !bus.Mem_OE && !bus.Mem_WE;
                end
                if (accept) next_state = (bus.ADDR == IO_ADDR) ? IO : ACCESS;
            end
            ACCESS: begin
                ce_n  = 1'b0;
                oe_n  = is_write;
                we_n  = !is_write;
                dq_oe = is_write;
                if (cnt == '0) next_state = DONE;
            end
            IO:      next_state = DONE;
            DONE: begin
                ready      = 1'b1;
                next_state = RELEASE;
            end
            // Hold here until the CPU drops its strobes so one request completes once.
            RELEASE: if (bus.Mem_OE && bus.Mem_WE) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            addr_q   <= '0;
            data_q   <= '0;
            dout_q   <= '0;
            hex_q    <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
            cnt      <= '0;
            is_write <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sw_meta <= bus.SW;
            sw_sync <= sw_meta;
            if (illegal) err_q <= 1'b1;
            if (accept) begin
                addr_q   <= bus.ADDR;
                data_q   <= bus.Data_CPU;
                is_write <= bus.Mem_OE;
                cnt      <= 4'(WAIT_STATES);
            end
            if (state == ACCESS) begin
                if (cnt == '0) begin
                    if (!is_write) dout_q <= bus.SRAM_DQ_in;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
            if (state == IO) begin
                if (is_write) hex_q  <= data_q;
                else          dout_q <= sw_sync;
            end
        end
    end

    assign bus.Data_to_CPU = dout_q;
    assign bus.Mem_Ready   = ready;
    assign bus.HEX_Data    = hex_q;
    assign bus.SRAM_ADDR   = {4'b0, addr_q};
    assign bus.SRAM_CE_N   = ce_n;
    assign bus.SRAM_OE_N   = oe_n;
    assign bus.SRAM_WE_N   = we_n;
    assign bus.SRAM_DQ_out = data_q;
    assign bus.SRAM_DQ_oe  = dq_oe;
    assign bus.Err_Flag    = err_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Randomized bench for mem_io_bridge: a transaction-level model predicts every output
// each cycle from the acceptance cycle and the access type.
module tb_mem_io_bridge;
    localparam int unsigned W   = 1;
    localparam logic [15:0] IOA = 16'hFFFF;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    mem_io_bridge_if bus();

    mem_io_bridge #(.WAIT_STATES(W), .IO_ADDR(IOA)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    logic [15:0] sram_rdata = '0;
    always_comb bus.SRAM_DQ_in = bus.SRAM_OE_N ? 16'hDEAD : sram_rdata;

    // Model state: the latest transaction plus the register contents before it.
    bit          txn_valid = 1'b0;
    int          t_acc     = 0;
    bit          t_io, t_wr;
    logic [15:0] t_addr, t_data, t_rdata, t_sw;
    logic [15:0] base_dout = '0;
    logic [15:0] base_hex  = '0;
    bit          err_armed = 1'b0;
    int          err_cyc   = 0;

    int ready_cnt = 0, oe_low = 0, we_low = 0, ce_low = 0, last_ready_k = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int done_k(input bit io);
        return io ? 2 : int'(W) + 2;
    endfunction

    always @(negedge Clk) begin : compare
        int k, d;
        bit acc;
        logic [15:0] ed, eh;
        if (Reset) begin
            k   = txn_valid ? cyc - t_acc + 1 : -100;
            d   = done_k(t_io);
            acc = txn_valid && !t_io && k >= 1 && k <= int'(W) + 1;
            ed  = base_dout;
            eh  = base_hex;
            if (txn_valid && k >= d) begin
                if (t_io && t_wr)  eh = t_data;
                else if (t_io)     ed = t_sw;
                else if (!t_wr)    ed = t_rdata;
            end
            chk("sram_ce_n", 32'(bus.SRAM_CE_N), 32'(!acc));
            chk("sram_oe_n", 32'(bus.SRAM_OE_N), 32'(!(acc && !t_wr)));
            chk("sram_we_n", 32'(bus.SRAM_WE_N), 32'(!(acc && t_wr)));
            chk("sram_dq_oe", 32'(bus.SRAM_DQ_oe), 32'(acc && t_wr));
            chk("mem_ready", 32'(bus.Mem_Ready), 32'(txn_valid && k == d));
            chk("data_to_cpu", 32'(bus.Data_to_CPU), 32'(ed));
            chk("hex_data", 32'(bus.HEX_Data), 32'(eh));
            chk("err_flag", 32'(bus.Err_Flag), 32'(err_armed && cyc >= err_cyc));
            if (acc) begin
                chk("sram_addr", 32'(bus.SRAM_ADDR), 32'({4'b0, t_addr}));
                if (t_wr) chk("sram_dq_out", 32'(bus.SRAM_DQ_out), 32'(t_data));
            end
            if (bus.Mem_Ready) begin
                ready_cnt++;
                last_ready_k = k;
            end
            if (!bus.SRAM_CE_N) ce_low++;
            if (!bus.SRAM_OE_N) oe_low++;
            if (!bus.SRAM_WE_N) we_low++;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Mem_CE = 1'($urandom_range(0, 1));
        bus.Mem_OE = 1'b1;
        bus.Mem_WE = 1'b1;
    endtask

    task automatic fold();
        if (txn_valid) begin
            if (t_io && t_wr) base_hex  = t_data;
            else if (t_io)    base_dout = t_sw;
            else if (!t_wr)   base_dout = t_rdata;
        end
        txn_valid = 1'b0;
    endtask

    task automatic clear_model();
        txn_valid = 1'b0;
        base_dout = '0;
        base_hex  = '0;
        err_armed = 1'b0;
    endtask

    // SW is made stable two edges ahead, then flipped at acceptance so only a
    // properly synchronized sample reaches Data_to_CPU.
    task automatic issue(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                         input logic [15:0] rdata, input logic [15:0] sw, input int hold);
        fold();
        bus.SW = sw;
        step();
        step();
        t_io = (addr == IOA); t_wr = wr; t_addr = addr; t_data = data;
        t_rdata = rdata; t_sw = sw;
        sram_rdata = rdata;
        t_acc = cyc + 1;
        txn_valid = 1'b1;
        bus.Mem_CE = 1'b0;
        bus.Mem_OE = wr;
        bus.Mem_WE = !wr;
        bus.ADDR = addr;
        bus.Data_CPU = data;
        bus.SW = ~sw;
        step();
        bus.ADDR = 16'($urandom);
        bus.Data_CPU = 16'($urandom);
        for (int i = 1; i < hold; i++) step();
        idle_inputs();
        for (int i = 0; i < done_k(t_io) + 2; i++) step();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin : stimulus
        int snap_r, snap_oe, snap_we, snap_ce;
        bus.Mem_CE = 1'b1; bus.Mem_OE = 1'b1; bus.Mem_WE = 1'b1;
        bus.ADDR = '0; bus.Data_CPU = '0; bus.SW = '0;
        #2 Reset = 1'b0;
        #1;
        chk("rst_ce_n", 32'(bus.SRAM_CE_N), 32'd1);
        chk("rst_oe_n", 32'(bus.SRAM_OE_N), 32'd1);
        chk("rst_we_n", 32'(bus.SRAM_WE_N), 32'd1);
        chk("rst_dq_oe", 32'(bus.SRAM_DQ_oe), 32'd0);
        chk("rst_ready", 32'(bus.Mem_Ready), 32'd0);
        chk("rst_dout", 32'(bus.Data_to_CPU), 32'd0);
        chk("rst_hex", 32'(bus.HEX_Data), 32'd0);
        chk("rst_err", 32'(bus.Err_Flag), 32'd0);
        chk("rst_sram_addr", 32'(bus.SRAM_ADDR), 32'd0);
        chk("rst_dq_out", 32'(bus.SRAM_DQ_out), 32'd0);
        step();
        step();
        Reset = 1'b1;

        snap_r = ready_cnt; snap_oe = oe_low;
        issue(1'b0, 16'h0040, 16'h5555, 16'hBEEF, 16'h1111, 1);
        chk("beef_oe_cycles", 32'(oe_low - snap_oe), 32'd2);
        chk("beef_ready_pulses", 32'(ready_cnt - snap_r), 32'd1);
        chk("beef_ready_cycle", 32'(last_ready_k), 32'd3);
        chk("beef_data", 32'(bus.Data_to_CPU), 32'h0000BEEF);

        snap_we = we_low;
        issue(1'b1, 16'h0100, 16'h1234, 16'h4321, 16'h2222, 1);
        chk("wr_we_cycles", 32'(we_low - snap_we), 32'd2);
        chk("wr_sram_addr", 32'(bus.SRAM_ADDR), 32'h00000100);
        chk("wr_dq_out", 32'(bus.SRAM_DQ_out), 32'h00001234);
        chk("wr_keeps_dout", 32'(bus.Data_to_CPU), 32'h0000BEEF);

        snap_ce = ce_low;
        issue(1'b1, IOA, 16'h00A5, 16'h0000, 16'h3333, 1);
        chk("io_wr_no_sram", 32'(ce_low - snap_ce), 32'd0);
        chk("io_wr_ready_cycle", 32'(last_ready_k), 32'd2);
        chk("io_wr_hex", 32'(bus.HEX_Data), 32'h000000A5);

        snap_ce = ce_low;
        issue(1'b0, IOA, 16'h0000, 16'h9999, 16'h0F0F, 1);
        chk("io_rd_no_sram", 32'(ce_low - snap_ce), 32'd0);
        chk("io_rd_data", 32'(bus.Data_to_CPU), 32'h00000F0F);

        snap_r = ready_cnt;
        issue(1'b0, 16'h0200, 16'h0000, 16'hCAFE, 16'h4444, 10);
        chk("held_ready_pulses", 32'(ready_cnt - snap_r), 32'd1);

        fold();
        snap_ce = ce_low;
        err_armed = 1'b1;
        err_cyc = cyc + 1;
        bus.Mem_CE = 1'b0; bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b0;
        step();
        step();
        idle_inputs();
        step();
        chk("illegal_no_sram", 32'(ce_low - snap_ce), 32'd0);
        chk("illegal_err", 32'(bus.Err_Flag), 32'd1);
        issue(1'b0, 16'h0300, 16'h0000, 16'h6B6B, 16'h5555, 2);
        chk("after_illegal_data", 32'(bus.Data_to_CPU), 32'h00006B6B);
        chk("err_sticky", 32'(bus.Err_Flag), 32'd1);

        for (int n = 0; n < 40; n++) begin
            bit io, wr;
            logic [15:0] a;
            io = ($urandom_range(0, 3) == 0);
            wr = 1'($urandom_range(0, 1));
            a  = io ? IOA : 16'($urandom_range(0, 16'hFFFE));
            issue(wr, a, 16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(1, 6));
        end

        fold();
        snap_r = ready_cnt;
        t_io = 1'b0; t_wr = 1'b0; t_addr = 16'h0022; t_data = '0;
        t_rdata = 16'h7777; t_sw = bus.SW;
        sram_rdata = 16'h7777;
        t_acc = cyc + 1;
        txn_valid = 1'b1;
        bus.Mem_CE = 1'b0; bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b1; bus.ADDR = 16'h0022;
        step();
        #2 Reset = 1'b0;
        clear_model();
        #1;
        chk("mid_rst_ce_n", 32'(bus.SRAM_CE_N), 32'd1);
        chk("mid_rst_oe_n", 32'(bus.SRAM_OE_N), 32'd1);
        chk("mid_rst_ready", 32'(bus.Mem_Ready), 32'd0);
        chk("mid_rst_dout", 32'(bus.Data_to_CPU), 32'd0);
        chk("mid_rst_err", 32'(bus.Err_Flag), 32'd0);
        idle_inputs();
        step();
        step();
        Reset = 1'b1;
        step();
        chk("mid_rst_no_ready", 32'(ready_cnt - snap_r), 32'd0);
        chk("mid_rst_dout_kept", 32'(bus.Data_to_CPU), 32'd0);

        issue(1'b0, 16'h0022, 16'h0000, 16'h8181, 16'h6666, 1);
        chk("post_rst_read", 32'(bus.Data_to_CPU), 32'h00008181);
        for (int n = 0; n < 10; n++) begin
            bit wr;
            wr = 1'($urandom_range(0, 1));
            issue(wr, ($urandom_range(0, 1) == 1) ? IOA : 16'($urandom_range(0, 16'hFFFE)),
                  16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(1, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
